// File: rtl/apb_gpio32_if.sv
// APB bus bundle for the GPIO register block.
// The slave drives read data and the tied-off handshake responses.
interface apb_gpio32_if;
  logic        PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic [5:0]  PADDR;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        PSLVERR;

  modport master (
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    output PRDATA, PREADY, PSLVERR
  );
endinterface

// File: rtl/apb_gpio32.sv
// APB register block for a 32-pin GPIO port: output/direction/AF/mode/speed
// registers toward the IO mux, synchronised input read-back and edge interrupts.
module apb_gpio32 #(
  parameter int NPIN        = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic        PCLK,
  input  logic        PRESETn,
  apb_gpio32_if.slave apb,
  output logic [31:0] GPIO_DI,
  output logic [31:0] GPIO_DIR,
  output logic [31:0] GPIO_AFC,
  output logic [63:0] GPIO_PM,
  output logic [63:0] GPIO_PS,
  input  logic [31:0] GPIO_DO,
  output logic        IRQ
);

  localparam logic [3:0] A_IDR  = 4'h0;
  localparam logic [3:0] A_ODR  = 4'h1;
  localparam logic [3:0] A_BSET = 4'h2;
  localparam logic [3:0] A_BCLR = 4'h3;
  localparam logic [3:0] A_DIR  = 4'h4;
  localparam logic [3:0] A_AFC  = 4'h5;
  localparam logic [3:0] A_PML  = 4'h6;
  localparam logic [3:0] A_PMH  = 4'h7;
  localparam logic [3:0] A_PSL  = 4'h8;
  localparam logic [3:0] A_PSH  = 4'h9;
  localparam logic [3:0] A_IER  = 4'hA;
  localparam logic [3:0] A_EDGE = 4'hB;
  localparam logic [3:0] A_ISR  = 4'hC;

  function automatic logic [31:0] pin_mask();
    logic [31:0] m;
    for (int i = 0; i < 32; i++) m[i] = (i < NPIN);
    return m;
  endfunction

  // Two mode/speed bits per pin, so a bit belongs to pin i/2.
  function automatic logic [63:0] field_mask();
    logic [63:0] m;
    for (int i = 0; i < 64; i++) m[i] = ((i / 2) < NPIN);
    return m;
  endfunction

  localparam logic [31:0] PMASK = pin_mask();
  localparam logic [63:0] FMASK = field_mask();

  logic [31:0] sync_p [SYNC_STAGES];
  logic [31:0] sync_in;
  logic [31:0] prev;
  logic [31:0] odr, dir, afc, ier, edge_sel, isr;
  logic [63:0] pm, ps;
  logic        irq;

  logic        wr;
  logic [3:0]  addr;
  logic [31:0] wdata;
  logic [31:0] clr;
  logic [31:0] rise, fall, evt;
  logic [31:0] isr_next;
  logic [31:0] rdata;
  logic        unused_addr_lsb;

  assign addr            = apb.PADDR[5:2];
  assign unused_addr_lsb = ^apb.PADDR[1:0];
  assign wr              = apb.PSEL & apb.PENABLE & apb.PWRITE;
  assign wdata           = apb.PWDATA & PMASK;

  // Input synchroniser: stage 0 samples the asynchronous pins.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_p[i] <= '0;
    end else begin
      sync_p[0] <= GPIO_DO & PMASK;
      for (int i = 1; i < SYNC_STAGES; i++) sync_p[i] <= sync_p[i-1];
    end
  end

  assign sync_in = sync_p[SYNC_STAGES-1];

  // Edge detect on the synchronised value; a same-cycle set beats a W1C clear.
  always_comb begin
    clr      = (wr && addr == A_ISR) ? wdata : '0;
    rise     = sync_in & ~prev;
    fall     = ~sync_in & prev;
    evt      = ier & ((edge_sel & fall) | (~edge_sel & rise));
    isr_next = ((isr & ~clr) | evt) & PMASK;
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      odr      <= '0;
      dir      <= '0;
      afc      <= '0;
      pm       <= '0;
      ps       <= '0;
      ier      <= '0;
      edge_sel <= '0;
      isr      <= '0;
      prev     <= '0;
      irq      <= 1'b0;
    end else begin
      if (wr) begin
        case (addr)
          A_ODR:   odr          <= wdata;
          A_BSET:  odr          <= odr | wdata;
          A_BCLR:  odr          <= odr & ~wdata;
          A_DIR:   dir          <= wdata;
          A_AFC:   afc          <= wdata;
          A_PML:   pm[31:0]     <= apb.PWDATA & FMASK[31:0];
          A_PMH:   pm[63:32]    <= apb.PWDATA & FMASK[63:32];
          A_PSL:   ps[31:0]     <= apb.PWDATA & FMASK[31:0];
          A_PSH:   ps[63:32]    <= apb.PWDATA & FMASK[63:32];
          A_IER:   ier          <= wdata;
          A_EDGE:  edge_sel     <= wdata;
          default: ;
        endcase
      end
      prev <= sync_in;
      isr  <= isr_next;
      irq  <= |(isr_next & ier);
    end
  end

  // Read mux is combinational; write-only and unmapped offsets return 0.
  always_comb begin
    rdata = '0;
    if (apb.PSEL && !apb.PWRITE) begin
      case (addr)
        A_IDR:   rdata = sync_in;
        A_ODR:   rdata = odr;
        A_DIR:   rdata = dir;
        A_AFC:   rdata = afc;
        A_PML:   rdata = pm[31:0];
        A_PMH:   rdata = pm[63:32];
        A_PSL:   rdata = ps[31:0];
        A_PSH:   rdata = ps[63:32];
        A_IER:   rdata = ier;
        A_EDGE:  rdata = edge_sel;
        A_ISR:   rdata = isr;
        default: rdata = '0;
      endcase
    end
  end

  assign apb.PRDATA  = rdata;
  assign apb.PREADY  = 1'b1;
  assign apb.PSLVERR = 1'b0;

  assign GPIO_DI  = odr;
  assign GPIO_DIR = dir;
  assign GPIO_AFC = afc;
  assign GPIO_PM  = pm;
  assign GPIO_PS  = ps;
  assign IRQ      = irq;

endmodule

// File: tb/tb_apb_gpio32.sv
// Directed bench for apb_gpio32: register access, set/clear, synchroniser
// latency, edge interrupts, set-beats-clear and asynchronous reset.
module tb_apb_gpio32;

  logic        clk;
  logic        rst_n;
  logic [31:0] gpio_di, gpio_dir, gpio_afc, gpio_do;
  logic [63:0] gpio_pm, gpio_ps;
  logic        irq;
  int          passed;
  int          total;

  apb_gpio32_if bus ();

  apb_gpio32 #(.NPIN(32), .SYNC_STAGES(2)) dut (
    .PCLK     (clk),
    .PRESETn  (rst_n),
    .apb      (bus),
    .GPIO_DI  (gpio_di),
    .GPIO_DIR (gpio_dir),
    .GPIO_AFC (gpio_afc),
    .GPIO_PM  (gpio_pm),
    .GPIO_PS  (gpio_ps),
    .GPIO_DO  (gpio_do),
    .IRQ      (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic apb_write(input logic [5:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    bus.PSEL = 1'b1; bus.PENABLE = 1'b0; bus.PWRITE = 1'b1; bus.PADDR = a; bus.PWDATA = d;
    @(posedge clk); #1;
    bus.PENABLE = 1'b1;
    @(posedge clk); #1;
    bus.PSEL = 1'b0; bus.PENABLE = 1'b0; bus.PWRITE = 1'b0;
  endtask

  task automatic apb_read(input logic [5:0] a, output logic [31:0] d);
    bus.PSEL = 1'b1; bus.PENABLE = 1'b0; bus.PWRITE = 1'b0; bus.PADDR = a;
    #1;
    d = bus.PRDATA;
    bus.PSEL = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    for (int k = 0; k < 16; k++) begin
      apb_read(6'(k * 4), d);
      total++;
      if (d !== 32'h0) $display("FAIL reset_read off=%0h got=%h exp=%h", k * 4, d, 32'h0);
      else passed++;
    end
    total++;
    if (bus.PREADY !== 1'b1 || bus.PSLVERR !== 1'b0)
      $display("FAIL ready_err got=%b%b exp=10", bus.PREADY, bus.PSLVERR);
    else passed++;
    total++;
    if ({gpio_di, gpio_dir, gpio_afc, gpio_pm, gpio_ps, irq} !== '0)
      $display("FAIL reset_outputs got nonzero exp=0");
    else passed++;
    apb_write(6'h18, 32'hFFFF_FFFF);
    apb_read(6'h18, d);
    total++;
    if (d !== 32'hFFFF_FFFF) $display("FAIL pm_lo_read got=%h exp=%h", d, 32'hFFFF_FFFF);
    else passed++;
    total++;
    if (gpio_pm !== 64'h0000_0000_FFFF_FFFF)
      $display("FAIL pm_output got=%h exp=%h", gpio_pm, 64'h0000_0000_FFFF_FFFF);
    else passed++;
    apb_write(6'h34, 32'hFFFF_FFFF);
    apb_read(6'h34, d);
    total++;
    if (d !== 32'h0) $display("FAIL unmapped got=%h exp=%h", d, 32'h0);
    else passed++;
  endtask

  task automatic test_odr_set_clr();
    logic [31:0] d;
    apb_write(6'h04, 32'h0000_F0F0);
    total++;
    if (gpio_di !== 32'h0000_F0F0) $display("FAIL odr_write got=%h exp=%h", gpio_di, 32'h0000_F0F0);
    else passed++;
    apb_write(6'h08, 32'h0000_000F);
    total++;
    if (gpio_di !== 32'h0000_F0FF) $display("FAIL bset got=%h exp=%h", gpio_di, 32'h0000_F0FF);
    else passed++;
    apb_write(6'h0C, 32'h0000_00F0);
    total++;
    if (gpio_di !== 32'h0000_F00F) $display("FAIL bclr got=%h exp=%h", gpio_di, 32'h0000_F00F);
    else passed++;
    apb_read(6'h04, d);
    total++;
    if (d !== 32'h0000_F00F) $display("FAIL odr_read got=%h exp=%h", d, 32'h0000_F00F);
    else passed++;
    apb_read(6'h08, d);
    total++;
    if (d !== 32'h0) $display("FAIL bset_read got=%h exp=%h", d, 32'h0);
    else passed++;
  endtask

  task automatic test_sync_latency();
    logic [31:0] d;
    @(negedge clk);
    gpio_do = 32'hA5A5_A5A5;
    @(posedge clk); #1;
    apb_read(6'h00, d);
    total++;
    if (d !== 32'h0) $display("FAIL idr_after1 got=%h exp=%h", d, 32'h0);
    else passed++;
    @(posedge clk); #1;
    apb_read(6'h00, d);
    total++;
    if (d !== 32'hA5A5_A5A5) $display("FAIL idr_after2 got=%h exp=%h", d, 32'hA5A5_A5A5);
    else passed++;
  endtask

  task automatic test_irq_rise();
    logic [31:0] d;
    @(negedge clk);
    gpio_do = 32'h0;
    repeat (4) @(posedge clk);
    apb_write(6'h28, 32'h1);
    apb_write(6'h2C, 32'h0);
    @(negedge clk);
    gpio_do = 32'h1;
    @(posedge clk);
    @(posedge clk); #1;
    apb_read(6'h30, d);
    total++;
    if (d !== 32'h0 || irq !== 1'b0) $display("FAIL isr_early got=%h/%b exp=0/0", d, irq);
    else passed++;
    @(posedge clk); #1;
    apb_read(6'h30, d);
    total++;
    if (d !== 32'h1 || irq !== 1'b1) $display("FAIL isr_rise got=%h/%b exp=1/1", d, irq);
    else passed++;
    @(negedge clk);
    gpio_do = 32'h2;
    repeat (4) @(posedge clk); #1;
    apb_read(6'h30, d);
    total++;
    if (d !== 32'h1) $display("FAIL isr_ignore1 got=%h exp=%h", d, 32'h1);
    else passed++;
    @(negedge clk);
    gpio_do = 32'h0;
    repeat (4) @(posedge clk); #1;
    apb_read(6'h30, d);
    total++;
    if (d !== 32'h1) $display("FAIL isr_ignore2 got=%h exp=%h", d, 32'h1);
    else passed++;
    apb_write(6'h30, 32'h1);
    apb_read(6'h30, d);
    total++;
    if (d !== 32'h0 || irq !== 1'b0) $display("FAIL isr_w1c got=%h/%b exp=0/0", d, irq);
    else passed++;
    // Disabling the enable keeps the pending bit but drops IRQ.
    @(negedge clk);
    gpio_do = 32'h1;
    repeat (4) @(posedge clk);
    apb_write(6'h28, 32'h0);
    @(posedge clk); #1;
    apb_read(6'h30, d);
    total++;
    if (d !== 32'h1 || irq !== 1'b0) $display("FAIL ier_off got=%h/%b exp=1/0", d, irq);
    else passed++;
    apb_write(6'h30, 32'h1);
  endtask

  task automatic test_set_beats_clear();
    logic [31:0] d;
    apb_write(6'h2C, 32'h8);
    apb_write(6'h28, 32'h8);
    @(negedge clk);
    gpio_do = 32'h9;
    repeat (4) @(posedge clk); #1;
    apb_read(6'h30, d);
    total++;
    if (d !== 32'h0) $display("FAIL rise_in_fall_mode got=%h exp=%h", d, 32'h0);
    else passed++;
    @(negedge clk);
    gpio_do = 32'h1;
    @(posedge clk); #1;
    bus.PSEL = 1'b1; bus.PENABLE = 1'b0; bus.PWRITE = 1'b1; bus.PADDR = 6'h30; bus.PWDATA = 32'h8;
    @(posedge clk); #1;
    bus.PENABLE = 1'b1;
    @(posedge clk); #1;
    bus.PSEL = 1'b0; bus.PENABLE = 1'b0; bus.PWRITE = 1'b0;
    apb_read(6'h30, d);
    total++;
    if (d !== 32'h8 || irq !== 1'b1) $display("FAIL set_beats_clr got=%h/%b exp=8/1", d, irq);
    else passed++;
  endtask

  task automatic test_async_reset();
    logic [31:0] d;
    apb_write(6'h04, 32'h0000_1234);
    apb_write(6'h10, 32'h0000_00FF);
    apb_write(6'h14, 32'h0000_00F0);
    apb_write(6'h1C, 32'h0000_0005);
    apb_write(6'h20, 32'h0000_0003);
    @(posedge clk); #1;
    bus.PSEL = 1'b1; bus.PENABLE = 1'b0; bus.PWRITE = 1'b1; bus.PADDR = 6'h04; bus.PWDATA = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    bus.PENABLE = 1'b1;
    total++;
    if (irq !== 1'b1 || gpio_di !== 32'h0000_1234) $display("FAIL pre_reset got=%b/%h exp=1/00001234", irq, gpio_di);
    else passed++;
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({gpio_di, gpio_dir, gpio_afc, gpio_pm, gpio_ps, irq} !== '0)
      $display("FAIL async_reset got=%h %h %h %h %h %b exp=0", gpio_di, gpio_dir, gpio_afc, gpio_pm, gpio_ps, irq);
    else passed++;
    bus.PSEL = 1'b0; bus.PENABLE = 1'b0; bus.PWRITE = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    apb_read(6'h04, d);
    total++;
    if (d !== 32'h0) $display("FAIL lost_write got=%h exp=%h", d, 32'h0);
    else passed++;
    apb_read(6'h30, d);
    total++;
    if (d !== 32'h0) $display("FAIL isr_after_reset got=%h exp=%h", d, 32'h0);
    else passed++;
  endtask

  initial begin
    passed      = 0;
    total       = 0;
    rst_n       = 1'b0;
    gpio_do     = 32'h0;
    bus.PSEL    = 1'b0;
    bus.PENABLE = 1'b0;
    bus.PWRITE  = 1'b0;
    bus.PADDR   = 6'h0;
    bus.PWDATA  = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    test_reset();
    test_odr_set_clr();
    test_sync_latency();
    test_irq_rise();
    test_set_beats_clear();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
